// File: rtl/sd_text_stats.sv
// Byte/line/word statistics (optional checksum, SD_TEXT_STATS_CHECKSUM_EN) over the SD reader byte stream, frozen at end of file.
// Latency: counters update 1 cycle after an outen cycle; led follows 1 cycle later.
// Backpressure: none; a byte is accepted on every outen cycle until DONE.
module sd_text_stats #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        outen,
    input  logic [7:0]  outbyte,
    input  logic        endFile,
    input  logic [1:0]  sel,
    output logic [15:0] led,
    output logic [2:0]  rgb_led,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [7:0] LF = 8'h0A;

    state_t           state, state_nxt;
    logic             endfile_d;
    logic [CNT_W-1:0] byte_cnt, line_cnt, word_cnt;
    logic [7:0]       last_byte;
    logic             prev_ws;
    logic             overflow;
`ifdef SD_TEXT_STATS_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    logic        eof_edge, accept, enter_done, is_ws;
    logic        byte_inc, line_inc, word_inc;
    logic        byte_sat, line_sat, word_sat, ovf_set;
    logic        final_nonempty;
    logic [7:0]  final_last;
    logic [15:0] led_nxt;

    assign eof_edge = endFile && !endfile_d;
    assign is_ws    = (outbyte == 8'h20) || (outbyte == 8'h09) ||
                      (outbyte == 8'h0A) || (outbyte == 8'h0D);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_done = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = outen;
                if (eof_edge) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end else if (outen) begin
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                accept = outen;
                if (eof_edge) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A byte arriving with the endFile edge is folded into the final-line check.
    assign final_nonempty = accept || (byte_cnt != '0);
    assign final_last     = accept ? outbyte : last_byte;

    assign byte_inc = accept;
    assign line_inc = (accept && (outbyte == LF)) ||
                      (enter_done && final_nonempty && (final_last != LF));
    assign word_inc = accept && !is_ws && prev_ws;

    assign byte_sat = &byte_cnt;
    assign line_sat = &line_cnt;
    assign word_sat = &word_cnt;
    assign ovf_set  = (byte_inc && byte_sat) || (line_inc && line_sat) ||
                      (word_inc && word_sat);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            endfile_d <= 1'b0;
            byte_cnt  <= '0;
            line_cnt  <= '0;
            word_cnt  <= '0;
            last_byte <= 8'h00;
            prev_ws   <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            endfile_d <= endFile;
            if (byte_inc && !byte_sat) byte_cnt <= byte_cnt + CNT_W'(1);
            if (line_inc && !line_sat) line_cnt <= line_cnt + CNT_W'(1);
            if (word_inc && !word_sat) word_cnt <= word_cnt + CNT_W'(1);
            if (accept) begin
                last_byte <= outbyte;
                prev_ws   <= is_ws;
            end
            if (ovf_set) overflow <= 1'b1;
        end
    end

`ifdef SD_TEXT_STATS_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       checksum <= 8'h00;
        else if (accept) checksum <= checksum + outbyte;
    end
`endif

    always_comb begin
        led_nxt = 16'h0000;
        case (sel)
            2'd0: led_nxt = 16'(byte_cnt);
            2'd1: led_nxt = 16'(line_cnt);
            2'd2: led_nxt = 16'(word_cnt);
`ifdef SD_TEXT_STATS_CHECKSUM_EN
            2'd3: led_nxt = {8'h00, checksum};
`else
            2'd3: led_nxt = 16'(32'(byte_cnt) >> 16);
`endif
            default: led_nxt = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) led <= 16'h0000;
        else       led <= led_nxt;
    end

    assign done    = (state == ST_DONE);
    assign rgb_led = {state == ST_RUN, state == ST_DONE, overflow};

endmodule

// File: tb/tb_sd_text_stats.sv
// Directed bench for sd_text_stats: a 32-bit instance and a CNT_W=4 instance share the same stimulus.
module tb_sd_text_stats;

    logic        clk = 1'b0;
    logic        rstn;
    logic        outen;
    logic [7:0]  outbyte;
    logic        endFile;
    logic [1:0]  sel;
    logic [15:0] led, led4;
    logic [2:0]  rgb_led, rgb4;
    logic        done, done4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sd_text_stats #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte),
        .endFile(endFile), .sel(sel), .led(led), .rgb_led(rgb_led), .done(done)
    );

    sd_text_stats #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .outen(outen), .outbyte(outbyte),
        .endFile(endFile), .sel(sel), .led(led4), .rgb_led(rgb4), .done(done4)
    );

    task automatic do_reset(input logic eof_level);
        rstn    = 1'b0;
        outen   = 1'b0;
        outbyte = 8'h00;
        endFile = eof_level;
        sel     = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        outen   = 1'b1;
        outbyte = b;
        @(posedge clk);
        #1;
        outen   = 1'b0;
        outbyte = 8'h00;
    endtask

    task automatic raise_eof();
        endFile = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_led(input logic [1:0] s, output logic [15:0] v, output logic [15:0] v4);
        sel = s;
        @(posedge clk);
        #1;
        v  = led;
        v4 = led4;
    endtask

    task automatic test_reset();
        logic [15:0] v, v4;
        rstn = 1'b0; outen = 1'b0; outbyte = 8'h00; endFile = 1'b0; sel = 2'd0;
        #12;
        checks++;
        if (led !== 16'h0000 || rgb_led !== 3'b000 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: led=%h rgb=%b done=%b expected 0000/000/0", led, rgb_led, done);
        end
        do_reset(1'b0);
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'h0000 || rgb_led !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle: line=%0d rgb=%b expected 0/000", v, rgb_led);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  str [8] = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64, 8'h0A, 8'h65, 8'h66};
        logic [15:0] v, v4;
        do_reset(1'b0);
        send_byte(str[0]);
        checks++;
        if (led !== 16'd0 || rgb_led !== 3'b100) begin
            fails++;
            $display("FAIL basic_first: led=%0d rgb=%b expected 0/100", led, rgb_led);
        end
        send_byte(str[1]);
        checks++;
        if (led !== 16'd1) begin
            fails++;
            $display("FAIL basic_latency: led=%0d expected 1", led);
        end
        for (int i = 2; i < 8; i++) send_byte(str[i]);
        raise_eof();
        checks++;
        if (done !== 1'b1 || rgb_led !== 3'b010) begin
            fails++;
            $display("FAIL basic_done: done=%b rgb=%b expected 1/010", done, rgb_led);
        end
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd8) begin fails++; $display("FAIL basic_bytes: got %0d expected 8", v); end
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'd2) begin fails++; $display("FAIL basic_lines: got %0d expected 2", v); end
        read_led(2'd2, v, v4);
        checks++;
        if (v !== 16'd3) begin fails++; $display("FAIL basic_words: got %0d expected 3", v); end
        read_led(2'd3, v, v4);
        checks++;
`ifdef SD_TEXT_STATS_CHECKSUM_EN
        if (v !== 16'h007F) begin fails++; $display("FAIL basic_sel3: got %h expected 007F", v); end
`else
        if (v !== 16'h0000) begin fails++; $display("FAIL basic_sel3: got %h expected 0000", v); end
`endif
        // Bytes in DONE must be ignored.
        send_byte(8'h41);
        send_byte(8'h0A);
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd8 || done !== 1'b1) begin
            fails++;
            $display("FAIL basic_frozen: bytes=%0d done=%b expected 8/1", v, done);
        end
    endtask

    task automatic test_empty();
        logic [15:0] v, v4;
        do_reset(1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || rgb_led !== 3'b010) begin
            fails++;
            $display("FAIL empty_done: done=%b rgb=%b expected 1/010", done, rgb_led);
        end
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd0) begin fails++; $display("FAIL empty_bytes: got %0d expected 0", v); end
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'd0) begin fails++; $display("FAIL empty_lines: got %0d expected 0", v); end
        read_led(2'd2, v, v4);
        checks++;
        if (v !== 16'd0) begin fails++; $display("FAIL empty_words: got %0d expected 0", v); end
    endtask

    task automatic test_ws_gaps();
        logic [7:0]  str [7] = '{8'h20, 8'h20, 8'h78, 8'h20, 8'h20, 8'h0A, 8'h0A};
        logic [15:0] v, v4;
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) begin
            send_byte(str[i]);
            repeat (i % 3) @(posedge clk);
            #1;
        end
        raise_eof();
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd7) begin fails++; $display("FAIL ws_bytes: got %0d expected 7", v); end
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'd2) begin fails++; $display("FAIL ws_lines: got %0d expected 2", v); end
        read_led(2'd2, v, v4);
        checks++;
        if (v !== 16'd1) begin fails++; $display("FAIL ws_words: got %0d expected 1", v); end
    endtask

    task automatic test_same_cycle_eof();
        logic [15:0] v, v4;
        do_reset(1'b0);
        send_byte(8'h61);
        send_byte(8'h0A);
        endFile = 1'b1;
        send_byte(8'h7A);
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL same_done: got %b expected 1", done); end
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd3) begin fails++; $display("FAIL same_bytes: got %0d expected 3", v); end
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'd2) begin fails++; $display("FAIL same_lines: got %0d expected 2", v); end
        read_led(2'd2, v, v4);
        checks++;
        if (v !== 16'd2) begin fails++; $display("FAIL same_words: got %0d expected 2", v); end
    endtask

    task automatic test_saturation();
        logic [15:0] v, v4;
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) send_byte(8'h78);
        checks++;
        if (rgb4 !== 3'b101 || rgb_led !== 3'b100) begin
            fails++;
            $display("FAIL sat_run_flags: rgb4=%b rgb=%b expected 101/100", rgb4, rgb_led);
        end
        raise_eof();
        read_led(2'd0, v, v4);
        checks++;
        if (v4 !== 16'd15 || v !== 16'd17) begin
            fails++;
            $display("FAIL sat_bytes: narrow=%0d wide=%0d expected 15/17", v4, v);
        end
        read_led(2'd2, v, v4);
        checks++;
        if (v4 !== 16'd1) begin fails++; $display("FAIL sat_words: got %0d expected 1", v4); end
        read_led(2'd1, v, v4);
        checks++;
        if (v4 !== 16'd1) begin fails++; $display("FAIL sat_lines: got %0d expected 1", v4); end
        checks++;
        if (rgb4 !== 3'b011 || done4 !== 1'b1 || rgb_led !== 3'b010) begin
            fails++;
            $display("FAIL sat_done_flags: rgb4=%b done4=%b rgb=%b expected 011/1/010", rgb4, done4, rgb_led);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0]  str [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        logic [15:0] v, v4;
        do_reset(1'b0);
        sel = 2'd0;
        for (int i = 0; i < 5; i++) send_byte(str[i]);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (led !== 16'd0 || rgb_led !== 3'b000) begin
            fails++;
            $display("FAIL midrst_async: led=%0d rgb=%b expected 0/000", led, rgb_led);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send_byte(8'h71);
        raise_eof();
        read_led(2'd0, v, v4);
        checks++;
        if (v !== 16'd1) begin fails++; $display("FAIL midrst_bytes: got %0d expected 1", v); end
        read_led(2'd1, v, v4);
        checks++;
        if (v !== 16'd1) begin fails++; $display("FAIL midrst_lines: got %0d expected 1", v); end
        read_led(2'd2, v, v4);
        checks++;
        if (v !== 16'd1) begin fails++; $display("FAIL midrst_words: got %0d expected 1", v); end
        checks++;
        if (rgb_led !== 3'b010) begin fails++; $display("FAIL midrst_rgb: got %b expected 010", rgb_led); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_ws_gaps();
        test_same_cycle_eof();
        test_saturation();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
